cv_weight_seq_ctrl: RTL

Sequencer that drives the read-side handshake (re_fm_en / re_fm_end) of the conv weights handler, one weights-buffer row per cycle.
- For each input tile it issues cfg_rows read cycles, then one terminating cycle that returns the handler's address to 0. It repeats this for cfg_tiles tiles.
- Honours a downstream stall and reports per-tile and per-job completion.
- Sits between the layer controller (start/config) and the weights handler plus pixel fetch path.

---
 rtl/cv_weight_seq_ctrl_if.sv | 44 ++++
 rtl/cv_weight_seq_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cv_weight_seq_ctrl_if.sv
// Start/config, stall and read-handshake bundle of the conv weight sequencer.
// The abort/aborted pair exists only when CV_WSEQ_ABORT_EN is defined.
interface cv_weight_seq_ctrl_if #(
    parameter int CNT_W  = 11,
    parameter int TILE_W = 16
);
    logic              start;
    logic [CNT_W-1:0]  cfg_rows;
    logic [TILE_W-1:0] cfg_tiles;
    logic              stall;
    logic              busy;
    logic              re_fm_en;
    logic              re_fm_end;
    logic [CNT_W-1:0]  row_cnt;
    logic [TILE_W-1:0] tile_idx;
    logic              tile_done;
    logic              done;
`ifdef CV_WSEQ_ABORT_EN
    logic              abort;
    logic              aborted;

    modport master (
        output start, cfg_rows, cfg_tiles, stall, abort,
        input  busy, re_fm_en, re_fm_end, row_cnt,
        input  tile_idx, tile_done, done, aborted
    );
    modport slave (
        input  start, cfg_rows, cfg_tiles, stall, abort,
        output busy, re_fm_en, re_fm_end, row_cnt,
        output tile_idx, tile_done, done, aborted
    );
`else
    modport master (
        output start, cfg_rows, cfg_tiles, stall,
        input  busy, re_fm_en, re_fm_end, row_cnt,
        input  tile_idx, tile_done, done
    );
    modport slave (
        input  start, cfg_rows, cfg_tiles, stall,
        output busy, re_fm_en, re_fm_end, row_cnt,
        output tile_idx, tile_done, done
    );
`endif
endinterface

// File: rtl/cv_weight_seq_ctrl.sv
// Row-per-cycle read sequencer for the conv weights handler, tile by tile.
// Define CV_WSEQ_ABORT_EN to add the abort input and aborted status output.
module cv_weight_seq_ctrl #(
    parameter int CNT_W   = 11,
    parameter int TILE_W  = 16,
    parameter int GAP_CYC = 1
) (
    input logic                 clk,
    input logic                 reset,
    cv_weight_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, READ, END, GAP, FIN
    } state_t;

    localparam logic [CNT_W-1:0]  ROW_ONE  = CNT_W'(1);
    localparam logic [TILE_W-1:0] TILE_ONE = TILE_W'(1);
    localparam logic [3:0] GAP_LAST = 4'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rows_q, rows_d, row_q, row_d;
    logic [TILE_W-1:0] tiles_q, tiles_d, tile_q, tile_d;
    logic [3:0]        gap_q, gap_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d, en_q, en_d, end_q, end_d;
    logic              tdone_q, tdone_d, done_q, done_d;
    logic              abrt_req, first_end;

    // A zero-row tile consists of its terminating cycle only.
    assign first_end = (state_q == IDLE) ? (bus.cfg_rows == '0)
                                         : (rows_q == '0);

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        tiles_d = tiles_q;
        row_d   = row_q;
        tile_d  = tile_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        en_d    = 1'b0;
        end_d   = 1'b0;
        tdone_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rows_d  = bus.cfg_rows;
                    tiles_d = bus.cfg_tiles;
                    row_d   = '0;
                    tile_d  = '0;
                    gap_d   = '0;
                    busy_d  = 1'b1;
                    if (bus.cfg_tiles == '0) begin
                        state_d = FIN;
                        hold_d  = 1'b1;
                    end else begin
                        state_d = first_end ? END : READ;
                        en_d    = 1'b1;
                        end_d   = first_end;
                        tdone_d = first_end;
                    end
                end
            end
            READ: begin
                if (!bus.stall) begin
                    en_d = 1'b1;
                    if (abrt_req || row_q == rows_q - ROW_ONE) begin
                        state_d = END;
                        row_d   = '0;
                        end_d   = 1'b1;
                        tdone_d = !abrt_req;
                    end else begin
                        row_d = row_q + ROW_ONE;
                    end
                end
            end
            END: begin
                if (!bus.stall) begin
                    if (abrt_req || tile_q == tiles_q - TILE_ONE) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        tile_d = tile_q + TILE_ONE;
                        if (GAP_CYC == 0) begin
                            state_d = first_end ? END : READ;
                            en_d    = 1'b1;
                            end_d   = first_end;
                            tdone_d = first_end;
                        end else begin
                            state_d = GAP;
                            gap_d   = '0;
                        end
                    end
                end
            end
            GAP: begin
                if (abrt_req) begin
                    // Return the handler address to 0 before finishing.
                    if (!bus.stall) begin
                        state_d = END;
                        en_d    = 1'b1;
                        end_d   = 1'b1;
                    end
                end else if (gap_q == GAP_LAST) begin
                    state_d = first_end ? END : READ;
                    row_d   = '0;
                    en_d    = 1'b1;
                    end_d   = first_end;
                    tdone_d = first_end;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            FIN: begin
                busy_d = 1'b0;
                if (hold_q) begin
                    hold_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rows_q  <= '0;
            tiles_q <= '0;
            row_q   <= '0;
            tile_q  <= '0;
            gap_q   <= '0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            end_q   <= 1'b0;
            tdone_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            tiles_q <= tiles_d;
            row_q   <= row_d;
            tile_q  <= tile_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            end_q   <= end_d;
            tdone_q <= tdone_d;
            done_q  <= done_d;
        end
    end

`ifdef CV_WSEQ_ABORT_EN
    logic abrt_q, aborted_q;

    assign abrt_req = abrt_q | bus.abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            abrt_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            abrt_q    <= (state_q == IDLE) ? 1'b0 : abrt_req;
            aborted_q <= done_d & abrt_req & (state_q == END);
        end
    end

    assign bus.aborted = aborted_q;
`else
    assign abrt_req = 1'b0;
`endif

    assign bus.busy      = busy_q;
    assign bus.re_fm_en  = en_q;
    assign bus.re_fm_end = end_q;
    assign bus.row_cnt   = row_q;
    assign bus.tile_idx  = tile_q;
    assign bus.tile_done = tdone_q;
    assign bus.done      = done_q;
endmodule
